multiplexor_7seg: RTL and testbench
===================================

# multiplexor_7seg

Time-multiplexed driver for a three-digit common-anode 7-segment display. It sits directly downstream of the 8-bit binary-to-BCD converter and latches that block's Centenas/Decenas/Unidades nibbles on a load strobe. It scans the three digits with a programmable refresh divider and drives active-low segment and anode lines. Leading-zero blanking and invalid-digit indication are built in.

## Interface
- DIV, 50000: clock cycles each digit stays lit; legal range 1..2^20-1
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  capture strobe; when high, Centenas/Decenas/Unidades are registered on this edge
- Centenas  input  4  hundreds BCD digit
- Decenas  input  4  tens BCD digit
- Unidades  input  4  units BCD digit
- blank_ceros  input  1  1 = blank leading zeros (sampled live every cycle, not latched)
- seg  output  7  segments, active-low, seg[6:0] = {g,f,e,d,c,b,a}
- an  output  3  anodes, active-low; an[0] = units, an[1] = tens, an[2] = hundreds

## Operation
- Digit registers dig_c, dig_d, dig_u:
  - Written when load=1.
  - Otherwise hold.
  - Reset to 0.
- Refresh counter cnt, width ceil(log2(DIV)):
  - Counts 0..DIV-1 and wraps to 0.
  - Terminal count is tc = (cnt == DIV-1).
- Scan FSM, states S_U → S_D → S_C → S_U:
  - Advances only on tc.
  - Reset state is S_U.
- Slot content per state:
  - S_U: digit dig_u, anode 3'b110.
  - S_D: digit dig_d, anode 3'b101.
  - S_C: digit dig_c, anode 3'b011.
- Blanking (blank_ceros=1 only):
  - S_C is blanked when dig_c==0.
  - S_D is blanked when dig_c==0 and dig_d==0.
  - S_U is never blanked.
  - Blanked slot: an=3'b111, seg=7'h7F.
- Decode, active-low hex values:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
  - Nibble 10..15 → dash 7'h3F (g only).
- Ghosting prevention: seg and an both come from the same registered stage, so they always change on the same edge.
- Simultaneous load and tc:
  - Both take effect on that edge.
  - The newly entered slot shows the new digit value.
- Load while a slot is lit: the displayed value changes one cycle later, without waiting for the slot end.
- Reset mid-scan:
  - cnt=0, state S_U, digits 0.
  - seg=7'h7F and an=3'b111 on the edge where rst=1 is sampled.

## Timing
- Outputs are registered: seg/an reflect state, digits and blank_ceros from the previous cycle (1-cycle latency).
- Reset values: seg=7'h7F, an=3'b111.
- First cycle after reset release shows S_U with digit 0: an=3'b110, seg=7'h40.
- Each slot lasts exactly DIV cycles at the outputs; full frame = 3·DIV cycles.
- DIV=1: the state advances every cycle and each slot shows for 1 cycle.
- Load-to-display latency: 2 cycles when the target slot is active (capture edge, then output register edge).

## Structure
- Package multiplexor_7seg_pkg holds:
  - Segment constants SEG_0..SEG_9, SEG_GUION (7'h3F), SEG_APAGADO (7'h7F).
  - Anode constants AN_U/AN_D/AN_C/AN_OFF.
  - FSM state enumeration.
- Sub-module decod_7seg: purely combinational, 4-bit nibble in, 7-bit active-low segment out, invalid nibble → SEG_GUION. Instantiated once on the mux output.
- Top level contains:
  - Digit registers.
  - Refresh counter.
  - FSM.
  - Blanking logic.
  - Output register.

## Test plan
- Reset and first slots (DIV=4): rst high 3 cycles → seg=7F, an=111. Release rst → next cycle an=110, seg=40, held for 4 cycles, then an=101.
- Full scan (DIV=4): load 2,5,5 with blank_ceros=0 → repeating 12-cycle frame:
  - an=110 seg=12
  - an=101 seg=12
  - an=011 seg=24
- Leading-zero blanking: load 0,0,7 with blank_ceros=1 → units slot seg=78. Tens and hundreds slots show an=111, seg=7F. Clear blank_ceros → those slots show seg=40.
- Invalid nibble: load Decenas=4'hC → tens slot seg=3F; other slots are unaffected.
- Load on terminal count: assert load with 1,2,3 on the cycle where the S_U slot ends → the following S_D slot shows seg=24 immediately.
- Reset mid-scan: assert rst during S_C → next output seg=7F, an=111. After release the scan restarts at S_U with digit 0 (seg=40).

Source files
------------

// File: rtl/multiplexor_7seg_pkg.sv
// Shared constants for the three-digit multiplexed 7-segment driver:
// active-low segment patterns, active-low anode patterns and scan states.
package multiplexor_7seg_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0       = 7'h40;
  localparam logic [6:0] SEG_1       = 7'h79;
  localparam logic [6:0] SEG_2       = 7'h24;
  localparam logic [6:0] SEG_3       = 7'h30;
  localparam logic [6:0] SEG_4       = 7'h19;
  localparam logic [6:0] SEG_5       = 7'h12;
  localparam logic [6:0] SEG_6       = 7'h02;
  localparam logic [6:0] SEG_7       = 7'h78;
  localparam logic [6:0] SEG_8       = 7'h00;
  localparam logic [6:0] SEG_9       = 7'h10;
  localparam logic [6:0] SEG_GUION   = 7'h3F;
  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  localparam logic [2:0] AN_U   = 3'b110;
  localparam logic [2:0] AN_D   = 3'b101;
  localparam logic [2:0] AN_C   = 3'b011;
  localparam logic [2:0] AN_OFF = 3'b111;

  typedef enum logic [1:0] {
    S_U = 2'd0,
    S_D = 2'd1,
    S_C = 2'd2
  } estado_t;

endpackage

// File: rtl/multiplexor_7seg_decod.sv
// BCD nibble to active-low 7-segment pattern; nibbles 10..15 show a dash.
module decod_7seg
  import multiplexor_7seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_GUION;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_GUION;
    endcase
  end

endmodule

// File: rtl/multiplexor_7seg.sv
// Three-digit common-anode display scanner: latches BCD digits on load,
// cycles units/tens/hundreds every DIV clocks, with leading-zero blanking.
module multiplexor_7seg
  import multiplexor_7seg_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] Centenas,
  input  logic [3:0] Decenas,
  input  logic [3:0] Unidades,
  input  logic       blank_ceros,
  output logic [6:0] seg,
  output logic [2:0] an
);

  // DIV=1 still needs a 1-bit counter so the compare stays well-formed.
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [3:0]    dig_c_q, dig_d_q, dig_u_q;
  logic [CW-1:0] cnt_q;
  estado_t       estado_q;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic          tc;
  estado_t       estado_d;
  logic [3:0]    digito_sel;
  logic [2:0]    an_sel;
  logic          apagar;
  logic [6:0]    seg_dec;

  assign tc = (cnt_q == CW'(DIV - 1));

  always_comb begin
    digito_sel = dig_u_q;
    an_sel     = AN_U;
    apagar     = 1'b0;
    estado_d   = S_U;
    case (estado_q)
      S_U: begin
        estado_d = S_D;
      end
      S_D: begin
        digito_sel = dig_d_q;
        an_sel     = AN_D;
        apagar     = blank_ceros && (dig_c_q == 4'd0) && (dig_d_q == 4'd0);
        estado_d   = S_C;
      end
      S_C: begin
        digito_sel = dig_c_q;
        an_sel     = AN_C;
        apagar     = blank_ceros && (dig_c_q == 4'd0);
        estado_d   = S_U;
      end
      default: begin
        estado_d = S_U;
      end
    endcase
  end

  decod_7seg u_decod (
    .nibble_i (digito_sel),
    .seg_o    (seg_dec)
  );

  assign seg_d = apagar ? SEG_APAGADO : seg_dec;
  assign an_d  = apagar ? AN_OFF : an_sel;

  // seg and an share one register stage so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_c_q  <= 4'd0;
      dig_d_q  <= 4'd0;
      dig_u_q  <= 4'd0;
      cnt_q    <= '0;
      estado_q <= S_U;
      seg_q    <= SEG_APAGADO;
      an_q     <= AN_OFF;
    end else begin
      if (load) begin
        dig_c_q <= Centenas;
        dig_d_q <= Decenas;
        dig_u_q <= Unidades;
      end
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
      if (tc) begin
        estado_q <= estado_d;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_multiplexor_7seg.sv
// Scoreboard bench: two scanners (DIV=4 and DIV=1) share stimulus; a cycle-count model predicts every output.
module tb_multiplexor_7seg;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] Centenas, Decenas, Unidades;
  logic       blank_ceros;
  logic [6:0] seg4, seg1;
  logic [2:0] an4, an1;

  int checks = 0;
  int errors = 0;

  logic [9:0] q4[$];
  logic [9:0] q1[$];

  // Model: count of non-reset edges since the last reset plus the captured digits.
  int         c_m = 0;
  logic [3:0] mc = 4'd0, md = 4'd0, mu = 4'd0;
  logic       bl_cur = 1'b0;

  multiplexor_7seg #(.DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .load(load),
    .Centenas(Centenas), .Decenas(Decenas), .Unidades(Unidades),
    .blank_ceros(blank_ceros), .seg(seg4), .an(an4)
  );

  multiplexor_7seg #(.DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .load(load),
    .Centenas(Centenas), .Decenas(Decenas), .Unidades(Unidades),
    .blank_ceros(blank_ceros), .seg(seg1), .an(an1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] pattern(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // slot 0 = units, 1 = tens, 2 = hundreds
  function automatic logic [9:0] render(input int slot, input logic [3:0] ci, di, ui,
                                        input logic bl);
    if (slot == 0) return {pattern(ui), 3'b110};
    if (slot == 1) begin
      if (bl && ci == 4'd0 && di == 4'd0) return {7'h7F, 3'b111};
      return {pattern(di), 3'b101};
    end
    if (bl && ci == 4'd0) return {7'h7F, 3'b111};
    return {pattern(ci), 3'b011};
  endfunction

  task automatic step(input logic r, input logic ld, input logic [3:0] ci, di, ui,
                      input logic bl);
    rst = r; load = ld; Centenas = ci; Decenas = di; Unidades = ui; blank_ceros = bl;
    if (r) begin
      q4.push_back({7'h7F, 3'b111});
      q1.push_back({7'h7F, 3'b111});
      c_m = 0; mc = 4'd0; md = 4'd0; mu = 4'd0;
    end else begin
      q4.push_back(render((c_m / 4) % 3, mc, md, mu, bl));
      q1.push_back(render(c_m % 3, mc, md, mu, bl));
      c_m++;
      if (ld) begin
        mc = ci; md = di; mu = ui;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, Centenas, Decenas, Unidades, bl_cur);
  endtask

  initial begin : monitor
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (q4.size() > 0) begin
        exp = q4.pop_front();
        checks++;
        if ({seg4, an4} !== exp) begin
          errors++;
          $display("FAIL div4 t=%0t seg=%h an=%b expected seg=%h an=%b",
                   $time, seg4, an4, exp[9:3], exp[2:0]);
        end else
          $display("ok   div4 t=%0t seg=%h an=%b", $time, seg4, an4);
      end
      if (q1.size() > 0) begin
        exp = q1.pop_front();
        checks++;
        if ({seg1, an1} !== exp) begin
          errors++;
          $display("FAIL div1 t=%0t seg=%h an=%b expected seg=%h an=%b",
                   $time, seg1, an1, exp[9:3], exp[2:0]);
        end else
          $display("ok   div1 t=%0t seg=%h an=%b", $time, seg1, an1);
      end
    end
  end

  initial begin : stimulus
    int guard;
    logic       r, ld, blr;
    logic [3:0] rc, rd, ru;

    repeat (3) step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    idle(14);

    step(1'b0, 1'b1, 4'd2, 4'd5, 4'd5, 1'b0);
    idle(26);

    bl_cur = 1'b1;
    step(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, bl_cur);
    idle(24);
    bl_cur = 1'b0;
    idle(12);

    step(1'b0, 1'b1, 4'd3, 4'hC, 4'd1, bl_cur);
    idle(12);

    // Last cycle of the units slot on the DIV=4 scanner.
    while (c_m % 12 != 3) idle(1);
    step(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, bl_cur);
    idle(12);

    // Reset while the hundreds slot is lit.
    while (c_m % 12 != 9) idle(1);
    step(1'b1, 1'b0, Centenas, Decenas, Unidades, bl_cur);
    idle(12);

    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      rc  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rd  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ru  = 4'($urandom_range(0, 15));
      blr = ($urandom_range(0, 15) == 0);
      if (blr) bl_cur = ~bl_cur;
      step(r, ld, rc, rd, ru, bl_cur);
    end

    guard = 0;
    while ((q4.size() > 0 || q1.size() > 0) && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (q4.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q4.size() + q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
